dsp_mac_sequencer: RTL and testbench

Controller that sequences one DSP slice (all pipeline regs enabled) through a length-N signed dot product, optionally seeded with a bias. It accepts operand pairs on a valid/ready stream and drives the slice's A/B/C/OPMODE/INMODE/ALUMODE/enable. It stalls the slice on input bubbles, flushes the pipeline after the last element, and returns the accumulated P on a valid/ready result port. It sits between the tile's operand fetch and the DSP instance.

---
 rtl/dsp_ctrl_pkg.sv | 22 ++
 rtl/dsp_mac_sequencer_if.sv | 25 ++
 rtl/dsp_sat_trunc.sv | 38 +++
 rtl/dsp_mac_sequencer.sv | 171 +++++++++++++++++
 tb/tb_dsp_mac_sequencer.sv | 316 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/dsp_ctrl_pkg.sv
// DSP slice control encodings and controller state shared by the MAC sequencer files.
package dsp_ctrl_pkg;

   localparam logic [8:0] OPMODE_FIRST_NB = 9'b000000101;
   localparam logic [8:0] OPMODE_FIRST_B  = 9'b110000101;
   localparam logic [8:0] OPMODE_ACC      = 9'b000100101;
   localparam logic [4:0] INMODE_AB       = 5'b00000;
   localparam logic [3:0] ALUMODE_ADD     = 4'b0000;

   typedef enum logic [1:0] {
      IDLE,
      ACC,
      FLUSH,
      RESULT
   } state_e;

   // First element restarts the accumulator: P = A*B, plus C when a bias is requested.
   function automatic logic [8:0] first_opmode(input logic bias_en);
      return bias_en ? OPMODE_FIRST_B : OPMODE_FIRST_NB;
   endfunction

endpackage

// File: rtl/dsp_mac_sequencer_if.sv
// Operand input stream and result output stream of the MAC sequencer.
interface dsp_mac_sequencer_if #(
   parameter int A_W   = 30,
   parameter int B_W   = 18,
   parameter int OUT_W = 32
);
   logic             in_valid;
   logic             in_ready;
   logic [A_W-1:0]   in_a;
   logic [B_W-1:0]   in_b;
   logic             out_valid;
   logic             out_ready;
   logic [OUT_W-1:0] out_data;
   logic             out_sat;

   modport master (
      output in_valid, in_a, in_b, out_ready,
      input  in_ready, out_valid, out_data, out_sat
   );

   modport slave (
      input  in_valid, in_a, in_b, out_ready,
      output in_ready, out_valid, out_data, out_sat
   );
endinterface

// File: rtl/dsp_sat_trunc.sv
// Narrows the accumulator P to the result width: two's complement wrap by default,
// signed clamp with a saturation flag when DSP_MAC_SAT_EN is defined.
module dsp_sat_trunc #(
   parameter int P_W   = 48,
   parameter int OUT_W = 32
) (
   input  logic [P_W-1:0]   p_i,
   output logic [OUT_W-1:0] data_o,
   output logic             sat_o
);

`ifdef DSP_MAC_SAT_EN
   logic [P_W-OUT_W-1:0] sign_match;

   // P fits when every bit from the result's sign bit upward repeats P's sign.
   genvar gi;
   generate
      for (gi = 0; gi < P_W - OUT_W; gi++) begin : g_match
         assign sign_match[gi] = (p_i[OUT_W-1+gi] == p_i[P_W-1]);
      end
   endgenerate

   always_comb begin
      data_o = p_i[OUT_W-1:0];
      sat_o  = ~&sign_match;
      if (sat_o) begin
         data_o = p_i[P_W-1] ? {1'b1, {(OUT_W-1){1'b0}}} : {1'b0, {(OUT_W-1){1'b1}}};
      end
   end
`else
   logic unused_hi_bits;

   assign unused_hi_bits = ^p_i[P_W-1:OUT_W];
   assign data_o         = p_i[OUT_W-1:0];
   assign sat_o          = 1'b0;
`endif

endmodule

// File: rtl/dsp_mac_sequencer.sv
// Sequences one fully pipelined DSP slice through a signed dot product with optional bias.
// Define DSP_MAC_SAT_EN to saturate the result to OUT_W instead of wrapping it.
module dsp_mac_sequencer
   import dsp_ctrl_pkg::*;
#(
   parameter int A_W     = 30,
   parameter int B_W     = 18,
   parameter int P_W     = 48,
   parameter int OUT_W   = 32,
   parameter int LEN_W   = 16,
   parameter int DSP_LAT = 3
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start_i,
   input  logic [LEN_W-1:0]   cfg_len_i,
   input  logic               cfg_bias_en_i,
   input  logic [P_W-1:0]     cfg_bias_i,
   output logic               busy_o,
   dsp_mac_sequencer_if.slave strm,
   output logic               dsp_enable_o,
   output logic [A_W-1:0]     dsp_a_o,
   output logic [B_W-1:0]     dsp_b_o,
   output logic [P_W-1:0]     dsp_c_o,
   output logic [8:0]         dsp_opmode_o,
   output logic [4:0]         dsp_inmode_o,
   output logic [3:0]         dsp_alumode_o,
   input  logic [P_W-1:0]     dsp_p_i
);

   localparam int FL_W = $clog2(DSP_LAT) + 1;

   state_e           state_q, state_d;
   logic [LEN_W-1:0] cnt_q, cnt_d;
   logic [LEN_W-1:0] len_q, len_d;
   logic             bias_en_q, bias_en_d;
   logic [P_W-1:0]   bias_q, bias_d;
   logic             first_q, first_d;
   logic [FL_W-1:0]  flush_q, flush_d;
   logic [OUT_W-1:0] data_q, data_d;
   logic             sat_q, sat_d;

   logic [OUT_W-1:0] narrow_data;
   logic             narrow_sat;
   logic             len_zero;
   logic             fire;
   logic             last_elem;
   logic             flush_done;

   dsp_sat_trunc #(
      .P_W   (P_W),
      .OUT_W (OUT_W)
   ) u_sat_trunc (
      .p_i    (dsp_p_i),
      .data_o (narrow_data),
      .sat_o  (narrow_sat)
   );

   assign len_zero   = (len_q == '0);
   assign fire       = (state_q == ACC) && !len_zero && strm.in_valid;
   assign last_elem  = (cnt_q == len_q - LEN_W'(1));
   assign flush_done = (flush_q == FL_W'(DSP_LAT - 1));

   assign busy_o        = (state_q != IDLE);
   assign dsp_c_o       = bias_q;
   assign dsp_inmode_o  = INMODE_AB;
   assign dsp_alumode_o = ALUMODE_ADD;
   assign strm.out_data = data_q;
   assign strm.out_sat  = sat_q;

   always_comb begin
      state_d        = state_q;
      cnt_d          = cnt_q;
      len_d          = len_q;
      bias_en_d      = bias_en_q;
      bias_d         = bias_q;
      first_d        = first_q;
      flush_d        = flush_q;
      data_d         = data_q;
      sat_d          = sat_q;
      strm.in_ready  = 1'b0;
      strm.out_valid = 1'b0;
      dsp_enable_o   = 1'b0;
      dsp_a_o        = '0;
      dsp_b_o        = '0;
      dsp_opmode_o   = OPMODE_ACC;

      case (state_q)
         IDLE: begin
            if (start_i) begin
               state_d   = ACC;
               len_d     = cfg_len_i;
               bias_en_d = cfg_bias_en_i;
               bias_d    = cfg_bias_i;
               cnt_d     = '0;
               first_d   = 1'b1;
            end
         end

         ACC: begin
            dsp_opmode_o = first_q ? first_opmode(bias_en_q) : OPMODE_ACC;
            if (len_zero) begin
               // Empty job still pushes one zero element so P ends up as bias or 0.
               dsp_enable_o = 1'b1;
               first_d      = 1'b0;
               flush_d      = '0;
               state_d      = FLUSH;
            end else begin
               strm.in_ready = 1'b1;
               dsp_enable_o  = strm.in_valid;
               if (fire) begin
                  dsp_a_o = strm.in_a;
                  dsp_b_o = strm.in_b;
                  cnt_d   = cnt_q + LEN_W'(1);
                  first_d = 1'b0;
                  if (last_elem) begin
                     flush_d = '0;
                     state_d = FLUSH;
                  end
               end
            end
         end

         FLUSH: begin
            // Zero operands under ACC leave P unchanged; the last cycle just samples P.
            dsp_enable_o = 1'b1;
            flush_d      = flush_q + FL_W'(1);
            if (flush_done) begin
               data_d  = narrow_data;
               sat_d   = narrow_sat;
               state_d = RESULT;
            end
         end

         RESULT: begin
            strm.out_valid = 1'b1;
            if (strm.out_ready) begin
               sat_d   = 1'b0;
               state_d = IDLE;
            end
         end

         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         len_q     <= '0;
         bias_en_q <= 1'b0;
         bias_q    <= '0;
         first_q   <= 1'b0;
         flush_q   <= '0;
         data_q    <= '0;
         sat_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         len_q     <= len_d;
         bias_en_q <= bias_en_d;
         bias_q    <= bias_d;
         first_q   <= first_d;
         flush_q   <= flush_d;
         data_q    <= data_d;
         sat_q     <= sat_d;
      end
   end

endmodule

// File: tb/tb_dsp_mac_sequencer.sv
// Bench for dsp_mac_sequencer paired with a behavioural three-stage DSP slice model.
module tb_dsp_mac_sequencer;
   import dsp_ctrl_pkg::*;

   localparam int A_W     = 30;
   localparam int B_W     = 18;
   localparam int P_W     = 48;
   localparam int OUT_W   = 32;
   localparam int LEN_W   = 16;
   localparam int DSP_LAT = 3;

   logic             clk = 1'b0;
   logic             rst = 1'b0;
   logic             start = 1'b0;
   logic [LEN_W-1:0] cfg_len = '0;
   logic             cfg_bias_en = 1'b0;
   logic [P_W-1:0]   cfg_bias = '0;
   logic             busy;
   logic             dsp_enable;
   logic [A_W-1:0]   dsp_a;
   logic [B_W-1:0]   dsp_b;
   logic [P_W-1:0]   dsp_c;
   logic [8:0]       dsp_opmode;
   logic [4:0]       dsp_inmode;
   logic [3:0]       dsp_alumode;
   logic [P_W-1:0]   dsp_p;

   dsp_mac_sequencer_if #(.A_W(A_W), .B_W(B_W), .OUT_W(OUT_W)) strm_if ();

   dsp_mac_sequencer #(
      .A_W(A_W), .B_W(B_W), .P_W(P_W), .OUT_W(OUT_W), .LEN_W(LEN_W), .DSP_LAT(DSP_LAT)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .start_i       (start),
      .cfg_len_i     (cfg_len),
      .cfg_bias_en_i (cfg_bias_en),
      .cfg_bias_i    (cfg_bias),
      .busy_o        (busy),
      .strm          (strm_if),
      .dsp_enable_o  (dsp_enable),
      .dsp_a_o       (dsp_a),
      .dsp_b_o       (dsp_b),
      .dsp_c_o       (dsp_c),
      .dsp_opmode_o  (dsp_opmode),
      .dsp_inmode_o  (dsp_inmode),
      .dsp_alumode_o (dsp_alumode),
      .dsp_p_i       (dsp_p)
   );

   always #5 clk = ~clk;

   // DSP slice model: input regs, multiplier pipe reg, output reg; controls travel with data.
   logic signed [A_W-1:0] m_a1 = '0;
   logic signed [B_W-1:0] m_b1 = '0;
   logic [P_W-1:0]        m_c1 = '0, m_c2 = '0;
   logic [8:0]            m_op1 = '0, m_op2 = '0;
   logic signed [P_W-1:0] m_m2 = '0, m_p3 = '0;
   logic signed [P_W-1:0] ext_a, ext_b, w_term, z_term;

   assign ext_a  = P_W'(m_a1);
   assign ext_b  = P_W'(m_b1);
   assign w_term = (m_op2[8:7] == 2'b11) ? m_c2 : '0;
   assign z_term = (m_op2[6:4] == 3'b010) ? m_p3 : '0;
   assign dsp_p  = m_p3;

   always @(posedge clk) begin
      if (dsp_enable) begin
         m_a1  <= dsp_a;
         m_b1  <= dsp_b;
         m_c1  <= dsp_c;
         m_op1 <= dsp_opmode;
         m_m2  <= ext_a * ext_b;
         m_c2  <= m_c1;
         m_op2 <= m_op1;
         m_p3  <= m_m2 + w_term + z_term;
      end
   end

   int checks = 0;
   int errors = 0;
   longint job_a[16];
   longint job_b[16];

   task automatic check(input string name, input longint act, input longint exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Reference: dot product plus optional bias in 48-bit arithmetic, then narrowed to 32 bits.
   function automatic void ref_model(input int len, input bit ben, input longint bias,
                                     output longint data, output bit sat);
      longint acc = ben ? bias : 0;
      for (int i = 0; i < len; i++) acc += job_a[i] * job_b[i];
      acc = (acc <<< (64 - P_W)) >>> (64 - P_W);
      sat = 1'b0;
`ifdef DSP_MAC_SAT_EN
      if (acc > 64'sd2147483647) begin
         data = 64'sd2147483647;
         sat  = 1'b1;
      end else if (acc < -64'sd2147483648) begin
         data = -64'sd2147483648;
         sat  = 1'b1;
      end else begin
         data = acc;
      end
`else
      data = longint'(int'(acc));
`endif
   endfunction

   task automatic run_job(input string name, input int len, input bit ben, input longint bias,
                          input int gap, input int hold, input longint exp, input bit exp_sat);
      int     n;
      longint got;
      start       = 1'b1;
      cfg_len     = LEN_W'(len);
      cfg_bias_en = ben;
      cfg_bias    = P_W'(bias);
      tick();
      start       = 1'b0;
      cfg_len     = '0;
      cfg_bias_en = 1'b0;
      cfg_bias    = '0;
      check({name, " busy"}, busy, 1);
      if (len == 0) begin
         check({name, " zero_ready"}, strm_if.in_ready, 0);
         check({name, " zero_en"}, dsp_enable, 1);
         check({name, " zero_op"}, dsp_opmode, ben ? OPMODE_FIRST_B : OPMODE_FIRST_NB);
         tick();
      end
      for (int i = 0; i < len; i++) begin
         for (int g = 0; g < gap; g++) begin
            strm_if.in_valid = 1'b0;
            #1;
            check({name, " gap_en"}, dsp_enable, 0);
            tick();
         end
         strm_if.in_valid = 1'b1;
         strm_if.in_a     = A_W'(job_a[i]);
         strm_if.in_b     = B_W'(job_b[i]);
         #1;
         check({name, " ready"}, strm_if.in_ready, 1);
         check({name, " dsp_a"}, $signed(dsp_a), job_a[i]);
         check({name, " opmode"}, dsp_opmode,
               (i == 0) ? (ben ? OPMODE_FIRST_B : OPMODE_FIRST_NB) : OPMODE_ACC);
         tick();
         strm_if.in_valid = 1'b0;
         strm_if.in_a     = '0;
         strm_if.in_b     = '0;
      end
      n = 0;
      while (!strm_if.out_valid && n < 20) begin
         tick();
         n++;
      end
      check({name, " latency"}, n, DSP_LAT);
      got = $signed(strm_if.out_data);
      check({name, " data"}, got, exp);
      check({name, " sat"}, strm_if.out_sat, exp_sat);
      for (int h = 0; h < hold; h++) begin
         start    = (h == 1);
         cfg_len  = 5;
         cfg_bias = 99;
         tick();
         start    = 1'b0;
         check({name, " hold_valid"}, strm_if.out_valid, 1);
         check({name, " hold_data"}, $signed(strm_if.out_data), exp);
         check({name, " hold_busy"}, busy, 1);
         check({name, " hold_c"}, $signed(dsp_c), bias);
      end
      cfg_len  = '0;
      cfg_bias = '0;
      strm_if.out_ready = 1'b1;
      tick();
      strm_if.out_ready = 1'b0;
      check({name, " done_valid"}, strm_if.out_valid, 0);
      check({name, " done_busy"}, busy, 0);
      $display("job %s len=%0d bias_en=%0d result=%0d sat=%0d", name, len, ben, got,
               strm_if.out_sat);
   endtask

   typedef struct {
      int     len;
      bit     ben;
      longint bias;
      int     gap;
      int     hold;
      longint a0, a1, a2;
      longint b0, b1, b2;
      longint exp;
      bit     exp_sat;
   } vec_t;

   vec_t vecs[7];

   initial begin
      #1000000;
      $display("FAIL watchdog timeout");
      $fatal(1, "simulation did not finish");
   end

   initial begin
      longint sat_exp;
      bit     sat_flag;
      longint exp;
      bit     exp_sat;
      int     len, gap, hold;
      bit     ben;
      longint bias, lim_a, lim_b;

`ifdef DSP_MAC_SAT_EN
      sat_exp  = 64'sd2147483647;
      sat_flag = 1'b1;
`else
      sat_exp  = 0;
      sat_flag = 1'b0;
`endif
      vecs[0] = '{len:3, ben:0, bias:0,  gap:0, hold:0, a0:1,  a1:2, a2:3, b0:4, b1:5,  b2:6,
                  exp:32,  exp_sat:0};
      vecs[1] = '{len:3, ben:0, bias:0,  gap:2, hold:0, a0:1,  a1:2, a2:3, b0:4, b1:5,  b2:6,
                  exp:32,  exp_sat:0};
      vecs[2] = '{len:0, ben:1, bias:7,  gap:0, hold:5, a0:0,  a1:0, a2:0, b0:0, b1:0,  b2:0,
                  exp:7,   exp_sat:0};
      vecs[3] = '{len:0, ben:0, bias:0,  gap:0, hold:0, a0:0,  a1:0, a2:0, b0:0, b1:0,  b2:0,
                  exp:0,   exp_sat:0};
      vecs[4] = '{len:1, ben:0, bias:0,  gap:0, hold:0, a0:1048576, a1:0, a2:0, b0:32768,
                  b1:0, b2:0, exp:sat_exp, exp_sat:sat_flag};
      vecs[5] = '{len:3, ben:1, bias:10, gap:0, hold:0, a0:1,  a1:2, a2:3, b0:4, b1:5,  b2:6,
                  exp:42,  exp_sat:0};
      vecs[6] = '{len:2, ben:0, bias:0,  gap:0, hold:0, a0:-2, a1:7, a2:0, b0:3, b1:-1, b2:0,
                  exp:-13, exp_sat:0};

      strm_if.in_valid  = 1'b0;
      strm_if.in_a      = '0;
      strm_if.in_b      = '0;
      strm_if.out_ready = 1'b0;

      rst = 1'b0;
      repeat (3) tick();
      check("rst busy", busy, 0);
      check("rst in_ready", strm_if.in_ready, 0);
      check("rst out_valid", strm_if.out_valid, 0);
      check("rst out_sat", strm_if.out_sat, 0);
      check("rst out_data", strm_if.out_data, 0);
      check("rst dsp_enable", dsp_enable, 0);
      check("rst dsp_a", dsp_a, 0);
      check("rst dsp_b", dsp_b, 0);
      check("rst dsp_c", dsp_c, 0);
      rst = 1'b1;
      tick();

      for (int k = 0; k < 7; k++) begin
         job_a[0] = vecs[k].a0; job_a[1] = vecs[k].a1; job_a[2] = vecs[k].a2;
         job_b[0] = vecs[k].b0; job_b[1] = vecs[k].b1; job_b[2] = vecs[k].b2;
         run_job($sformatf("vec%0d", k), vecs[k].len, vecs[k].ben, vecs[k].bias,
                 vecs[k].gap, vecs[k].hold, vecs[k].exp, vecs[k].exp_sat);
      end

      // Abort a 3-element biased job after two elements; the next job must start clean.
      start       = 1'b1;
      cfg_len     = 3;
      cfg_bias_en = 1'b1;
      cfg_bias    = 1000;
      tick();
      start = 1'b0;
      for (int i = 0; i < 2; i++) begin
         strm_if.in_valid = 1'b1;
         strm_if.in_a     = 7;
         strm_if.in_b     = 9;
         tick();
      end
      strm_if.in_valid = 1'b0;
      rst = 1'b0;
      tick();
      rst = 1'b1;
      check("abort busy", busy, 0);
      check("abort in_ready", strm_if.in_ready, 0);
      check("abort out_valid", strm_if.out_valid, 0);
      check("abort out_data", strm_if.out_data, 0);
      check("abort dsp_enable", dsp_enable, 0);
      check("abort dsp_c", dsp_c, 0);
      job_a[0] = 5;
      job_b[0] = 5;
      run_job("after_abort", 1, 1'b0, 0, 0, 0, 25, 1'b0);

      for (int r = 0; r < 10; r++) begin
         len  = $urandom_range(1, 6);
         ben  = 1'($urandom_range(0, 1));
         bias = longint'($urandom_range(0, 200000)) - 100000;
         gap  = $urandom_range(0, 2);
         hold = $urandom_range(0, 3);
         for (int i = 0; i < len; i++) begin
            lim_a = ($urandom_range(0, 3) == 0) ? 1048576 : 1000;
            lim_b = ($urandom_range(0, 3) == 0) ? 65536 : 1000;
            job_a[i] = longint'($urandom_range(0, 32'(2 * lim_a))) - lim_a;
            job_b[i] = longint'($urandom_range(0, 32'(2 * lim_b))) - lim_b;
            if (job_b[i] > 131071) job_b[i] = 131071;
         end
         ref_model(len, ben, bias, exp, exp_sat);
         run_job($sformatf("rand%0d", r), len, ben, bias, gap, hold, exp, exp_sat);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
